// File: rtl/dlinked_list.sv
// rtl/dlinked_list.sv - doubly-linked-list engine with insert/pop at both ends, delete-by-value, traversal
// Optional seven-segment readout of the last dout value when LL_SEG_DISPLAY_EN is defined.
module dlinked_list #(
   parameter int DATA_W    = 8,
   parameter int NUM_NODES = 8
`ifdef LL_SEG_DISPLAY_EN
   , parameter int REFRESH_BITS = 17
`endif
) (
   input  logic                             clk,
   input  logic                             btnC,
   input  logic [2:0]                       op,
   input  logic [DATA_W-1:0]                din,
   output logic                             busy,
   output logic                             done,
   output logic [DATA_W-1:0]                dout,
   output logic                             dout_valid,
   output logic [$clog2(NUM_NODES+1)-1:0]   count,
   output logic                             overflow,
   output logic                             underflow,
   output logic                             not_found
`ifdef LL_SEG_DISPLAY_EN
   , output logic [3:0]                     an
   , output logic [6:0]                     seg
`endif
);

   localparam int IDX_W = $clog2(NUM_NODES);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(NUM_NODES + 1);
   localparam logic [PTR_W-1:0] NIL = {PTR_W{1'b1}};

   localparam logic [2:0] OP_IDLE     = 3'b000;
   localparam logic [2:0] OP_POP_HEAD = 3'b001;
   localparam logic [2:0] OP_TRAV_REV = 3'b011;
   localparam logic [2:0] OP_INS_HEAD = 3'b100;
   localparam logic [2:0] OP_DELETE   = 3'b110;
   localparam logic [2:0] OP_TRAV_FWD = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SEARCH, S_WALK} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d, op_prev_q;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, cur_q, cur_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   data_q [NUM_NODES];
   logic [DATA_W-1:0]   data_d [NUM_NODES];
   logic [PTR_W-1:0]    next_q [NUM_NODES];
   logic [PTR_W-1:0]    next_d [NUM_NODES];
   logic [PTR_W-1:0]    prev_q [NUM_NODES];
   logic [PTR_W-1:0]    prev_d [NUM_NODES];
   logic [NUM_NODES-1:0] free_q, free_d;
   logic                done_q, done_d, dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                ovf_q, ovf_d, unf_q, unf_d, nf_q, nf_d;

   logic [IDX_W-1:0]    free_idx;
   logic [PTR_W-1:0]    ins_p, pop_p, nbr_p, nbr_n, walk_nx;

   function automatic logic [IDX_W-1:0] idx(input logic [PTR_W-1:0] p);
      return p[IDX_W-1:0];
   endfunction

   // Lowest-index free slot wins: scan downward so the last hit is the smallest.
   always_comb begin
      free_idx = '0;
      for (int i = NUM_NODES - 1; i >= 0; i--) begin
         if (free_q[i]) free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      din_d        = din_q;
      head_d       = head_q;
      tail_d       = tail_q;
      cur_d        = cur_q;
      count_d      = count_q;
      data_d       = data_q;
      next_d       = next_q;
      prev_d       = prev_q;
      free_d       = free_q;
      done_d       = 1'b0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      ovf_d        = ovf_q;
      unf_d        = unf_q;
      nf_d         = nf_q;
      ins_p        = {1'b0, free_idx};
      pop_p        = (op_q == OP_POP_HEAD) ? head_q : tail_q;
      nbr_p        = prev_q[idx(cur_q)];
      nbr_n        = next_q[idx(cur_q)];
      walk_nx      = (op_q == OP_TRAV_FWD) ? next_q[idx(cur_q)] : prev_q[idx(cur_q)];

      unique case (state_q)
         S_IDLE: begin
            if (op != OP_IDLE && op_prev_q == OP_IDLE) begin
               op_d  = op;
               din_d = din;
               ovf_d = 1'b0;
               unf_d = 1'b0;
               nf_d  = 1'b0;
               if (op == OP_TRAV_FWD || op == OP_DELETE) begin
                  cur_d   = head_q;
                  state_d = (op == OP_DELETE) ? S_SEARCH : S_WALK;
               end else if (op == OP_TRAV_REV) begin
                  cur_d   = tail_q;
                  state_d = S_WALK;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end

         S_EXEC: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (op_q[2]) begin
               if (count_q == CNT_W'(NUM_NODES)) begin
                  ovf_d = 1'b1;
               end else begin
                  data_d[free_idx] = din_q;
                  free_d[free_idx] = 1'b0;
                  count_d          = count_q + CNT_W'(1);
                  if (head_q == NIL) begin
                     next_d[free_idx] = NIL;
                     prev_d[free_idx] = NIL;
                     head_d           = ins_p;
                     tail_d           = ins_p;
                  end else if (op_q == OP_INS_HEAD) begin
                     next_d[free_idx]    = head_q;
                     prev_d[free_idx]    = NIL;
                     prev_d[idx(head_q)] = ins_p;
                     head_d              = ins_p;
                  end else begin
                     prev_d[free_idx]    = tail_q;
                     next_d[free_idx]    = NIL;
                     next_d[idx(tail_q)] = ins_p;
                     tail_d              = ins_p;
                  end
               end
            end else begin
               if (count_q == '0) begin
                  unf_d = 1'b1;
               end else begin
                  dout_d              = data_q[idx(pop_p)];
                  dout_valid_d        = 1'b1;
                  free_d[idx(pop_p)]  = 1'b1;
                  count_d             = count_q - CNT_W'(1);
                  if (op_q == OP_POP_HEAD) begin
                     head_d = next_q[idx(pop_p)];
                     if (next_q[idx(pop_p)] == NIL) tail_d = NIL;
                     else prev_d[idx(next_q[idx(pop_p)])] = NIL;
                  end else begin
                     tail_d = prev_q[idx(pop_p)];
                     if (prev_q[idx(pop_p)] == NIL) head_d = NIL;
                     else next_d[idx(prev_q[idx(pop_p)])] = NIL;
                  end
               end
            end
         end

         S_SEARCH: begin
            if (cur_q == NIL) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (count_q == '0) unf_d = 1'b1;
               else nf_d = 1'b1;
            end else if (data_q[idx(cur_q)] == din_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (nbr_p == NIL) head_d = nbr_n;
               else next_d[idx(nbr_p)] = nbr_n;
               if (nbr_n == NIL) tail_d = nbr_p;
               else prev_d[idx(nbr_n)] = nbr_p;
               free_d[idx(cur_q)] = 1'b1;
               count_d            = count_q - CNT_W'(1);
            end else begin
               cur_d = nbr_n;
            end
         end

         S_WALK: begin
            if (cur_q == NIL) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               dout_d       = data_q[idx(cur_q)];
               dout_valid_d = 1'b1;
               cur_d        = walk_nx;
               if (walk_nx == NIL) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      op_prev_q <= op;
      if (btnC) begin
         state_q      <= S_IDLE;
         op_q         <= OP_IDLE;
         din_q        <= '0;
         head_q       <= NIL;
         tail_q       <= NIL;
         cur_q        <= NIL;
         count_q      <= '0;
         free_q       <= '1;
         done_q       <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         nf_q         <= 1'b0;
         for (int i = 0; i < NUM_NODES; i++) begin
            data_q[i] <= '0;
            next_q[i] <= NIL;
            prev_q[i] <= NIL;
         end
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         din_q        <= din_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         cur_q        <= cur_d;
         count_q      <= count_d;
         free_q       <= free_d;
         done_q       <= done_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         nf_q         <= nf_d;
         data_q       <= data_d;
         next_q       <= next_d;
         prev_q       <= prev_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign overflow   = ovf_q;
   assign underflow  = unf_q;
   assign not_found  = nf_q;

`ifdef LL_SEG_DISPLAY_EN
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [15:0]             disp_q, disp_d;
   logic [DATA_W+15:0]      dout_wide;
   logic [1:0]              digit_sel;
   logic [3:0]              an_q, an_d;
   logic [6:0]              seg_q, seg_d;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // an[0] is the rightmost digit and shows the low nibble.
   always_comb begin
      refresh_d = refresh_q + REFRESH_BITS'(1);
      dout_wide = {16'b0, dout_d};
      disp_d    = dout_valid_d ? dout_wide[15:0] : disp_q;
      digit_sel = refresh_q[REFRESH_BITS-1 -: 2];
      an_d      = ~(4'b0001 << digit_sel);
      seg_d     = ~hex7(disp_q[{digit_sel, 2'b00} +: 4]);
   end

   always_ff @(posedge clk) begin
      if (btnC) begin
         refresh_q <= '0;
         disp_q    <= '0;
         an_q      <= 4'b1111;
         seg_q     <= 7'b1111111;
      end else begin
         refresh_q <= refresh_d;
         disp_q    <= disp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_dlinked_list.sv
// tb/tb_dlinked_list.sv - randomized bench for dlinked_list against a queue-based list model
module tb_dlinked_list;
   localparam int DW = 8;
   localparam int NN = 4;
   localparam int CW = $clog2(NN + 1);
   localparam int LIM = 20;

   logic          clk = 1'b0;
   logic          btnC;
   logic [2:0]    op;
   logic [DW-1:0] din;
   logic          busy, done, dout_valid, overflow, underflow, not_found;
   logic [DW-1:0] dout;
   logic [CW-1:0] count;
`ifdef LL_SEG_DISPLAY_EN
   logic [3:0]    an;
   logic [6:0]    seg;
`endif

   int vectors = 0;
   int miscompares = 0;
   int model[$];

   dlinked_list #(
      .DATA_W(DW),
      .NUM_NODES(NN)
`ifdef LL_SEG_DISPLAY_EN
      , .REFRESH_BITS(6)
`endif
   ) dut (
      .clk(clk), .btnC(btnC), .op(op), .din(din),
      .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
      .count(count), .overflow(overflow), .underflow(underflow), .not_found(not_found)
`ifdef LL_SEG_DISPLAY_EN
      , .an(an), .seg(seg)
`endif
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      btnC = 1'b1;
      @(negedge clk);
      btnC = 1'b0;
      model.delete();
   endtask

   task automatic run_cmd(input logic [2:0] c, input int d);
      int exp_out[$];
      int got_out[$];
      int exp_lat, ovf, unf, nf, j, done_k;
      ovf = 0; unf = 0; nf = 0; j = -1; done_k = -1; exp_lat = 1;
      case (c)
         3'b100, 3'b101: begin
            if (model.size() == NN) ovf = 1;
            else if (c == 3'b100) model.push_front(d & 8'hFF);
            else model.push_back(d & 8'hFF);
         end
         3'b001: if (model.size() == 0) unf = 1; else exp_out.push_back(model.pop_front());
         3'b010: if (model.size() == 0) unf = 1; else exp_out.push_back(model.pop_back());
         3'b110: begin
            if (model.size() == 0) unf = 1;
            else begin
               foreach (model[i]) if (j < 0 && model[i] == (d & 8'hFF)) j = i;
               if (j < 0) begin
                  nf = 1;
                  exp_lat = 1 + model.size();
               end else begin
                  exp_lat = 1 + j;
                  model.delete(j);
               end
            end
         end
         3'b111: begin
            exp_out = model;
            exp_lat = (model.size() == 0) ? 1 : model.size();
         end
         default: begin
            for (int i = model.size() - 1; i >= 0; i--) exp_out.push_back(model[i]);
            exp_lat = (model.size() == 0) ? 1 : model.size();
         end
      endcase

      @(negedge clk);
      op  = c;
      din = 8'(d);
      @(negedge clk);
      expect_eq("busy_after_accept", int'(busy), 1);
      for (int k = 1; k <= LIM; k++) begin
         if (k == 2) op = 3'b000;
         @(negedge clk);
         if (dout_valid) got_out.push_back(int'(dout));
         if (done) begin
            done_k = k;
            break;
         end
      end
      op = 3'b000;
      expect_eq($sformatf("latency_op%0d", c), done_k, exp_lat);
      expect_eq("busy_at_done", int'(busy), 0);
      expect_eq("dout_count", got_out.size(), exp_out.size());
      for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
         expect_eq($sformatf("dout[%0d]", i), got_out[i], exp_out[i]);
      expect_eq("count", int'(count), model.size());
      expect_eq("overflow", int'(overflow), ovf);
      expect_eq("underflow", int'(underflow), unf);
      expect_eq("not_found", int'(not_found), nf);
   endtask

`ifdef LL_SEG_DISPLAY_EN
   function automatic logic [6:0] seg_of(input int v);
      logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return ~tbl[v & 15];
   endfunction

   task automatic check_display(input int val);
      int pos;
      repeat (2) @(negedge clk);
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         expect_eq("an_onehot_low", $countones(~an), 1);
         pos = 0;
         for (int b = 0; b < 4; b++) if (!an[b]) pos = b;
         expect_eq($sformatf("seg_digit%0d", pos), int'(seg), int'(seg_of(val >> (4 * pos))));
      end
   endtask
`endif

   initial begin
      logic [2:0] codes [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      logic [2:0] c;
      int d;
      btnC = 1'b0;
      op   = 3'b000;
      din  = '0;
      do_reset();
      do_reset();
      expect_eq("rst_busy", int'(busy), 0);
      expect_eq("rst_done", int'(done), 0);
      expect_eq("rst_dout", int'(dout), 0);
      expect_eq("rst_dout_valid", int'(dout_valid), 0);
      expect_eq("rst_count", int'(count), 0);
      expect_eq("rst_flags", int'({overflow, underflow, not_found}), 0);

      run_cmd(3'b100, 1);
      run_cmd(3'b100, 3);
      run_cmd(3'b101, 7);
      run_cmd(3'b101, 15);
      run_cmd(3'b111, 0);
      run_cmd(3'b100, 8'h2F);
      run_cmd(3'b011, 0);
      run_cmd(3'b110, 1);
      run_cmd(3'b110, 8'h87);
      run_cmd(3'b001, 0);
      run_cmd(3'b010, 0);
      run_cmd(3'b110, 7);
      run_cmd(3'b001, 0);
      run_cmd(3'b110, 5);
      for (int i = 0; i < NN; i++) run_cmd(3'b101, 20 + i);
      run_cmd(3'b100, 99);

      // abort a traversal with reset while the opcode stays asserted
      @(negedge clk);
      op = 3'b111;
      repeat (2) @(negedge clk);
      btnC = 1'b1;
      @(negedge clk);
      btnC = 1'b0;
      model.delete();
      expect_eq("abort_busy", int'(busy), 0);
      expect_eq("abort_count", int'(count), 0);
      expect_eq("abort_dout_valid", int'(dout_valid), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_eq("held_op_no_start", int'(busy), 0);
      end
      op = 3'b000;
      run_cmd(3'b111, 0);
      run_cmd(3'b101, 42);
      run_cmd(3'b110, 42);
      run_cmd(3'b011, 0);

`ifdef LL_SEG_DISPLAY_EN
      run_cmd(3'b100, 8'hA5);
      run_cmd(3'b001, 0);
      check_display(8'hA5);
`endif

      for (int n = 0; n < 120; n++) begin
         c = codes[$urandom_range(0, 6)];
         d = $urandom_range(0, 15);
         if (c == 3'b110 && model.size() > 0 && $urandom_range(0, 1) == 1)
            d = model[$urandom_range(0, model.size() - 1)];
         run_cmd(c, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
